decoder_hadd: RTL and testbench
===============================

Name: decoder_hadd

Overview:
- Registered 2-input decode/add cell, LANES parallel lanes of inputs a and b.
- Per lane it produces:
  - sum S = a XOR b
  - carry Cout = a AND b
  - a one-hot 2-to-4 decode of the code {a,b}
- Keeps saturating occurrence counters per input code, used as a coverage/statistics tap.
- Sits between upstream control logic and consumers that need either the arithmetic form (S/Cout) or the one-hot form of the same 2-bit code.

Parameters:
- LANES, 1, number of independent a/b lanes.
- CNT_W, 16, width of each occurrence counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b sampled this cycle when high.
- a  input  LANES  operand A per lane.
- b  input  LANES  operand B per lane.
- clr_cnt  input  1  synchronous clear of all occurrence counters.
- out_valid  output  1  S/Cout/y valid.
- S  output  LANES  registered a^b per lane.
- Cout  output  LANES  registered a&b per lane.
- y  output  4*LANES  one-hot decode per lane. Lane i occupies y[4i+3:4i]; bit k is set when {a[i],b[i]}==k.
- cnt  output  4*CNT_W  occurrence counters for lane 0. Counter k occupies cnt[CNT_W*k +: CNT_W] and counts code {a[0],b[0]}==k.

Behaviour:
- Reset (rst_n low, async, any time): out_valid=0, S=0, Cout=0, y=0, all cnt=0. Outputs hold these values until the first in_valid after release.
- Latency is exactly 1 cycle. On a rising clk with in_valid=1, the registers load:
  - S=a^b
  - Cout=a&b
  - y one-hot from {a,b}
  - out_valid=1
- On a rising clk with in_valid=0:
  - out_valid=0 and y=0.
  - S and Cout hold their previous values; they are don't-care for consumers.
- Truth table per lane, {a,b} -> S,Cout,y:
  - 00 -> 0,0,0001
  - 01 -> 1,0,0010
  - 10 -> 1,0,0100
  - 11 -> 0,1,1000
- Invariants whenever out_valid=1:
  - Each lane's y nibble has exactly one bit set.
  - S==y[1]|y[2].
  - Cout==y[3].
- Counters:
  - On each accepted input (in_valid=1), counter[{a[0],b[0]}] increments by 1.
  - At 2^CNT_W-1 the counter holds; it never wraps.
- clr_cnt=1 at a clock edge zeroes all four counters. clr_cnt has priority over a simultaneous increment: the result is 0, and that sample is not counted.
- clr_cnt does not affect S, Cout, y or out_valid.
- No backpressure: every in_valid cycle is accepted.
- Reset asserted mid-stream discards any pending result. out_valid drops immediately (asynchronously).

Decomposition:
- Shared package decoder_pkg:
  - code typedef (2-bit)
  - localparams CODE_00..CODE_11
  - a function onehot4(code) returning a 4-bit one-hot.
- One natural sub-module: decoder_hadd_lane (combinational a,b -> S,Cout,y[3:0]), instantiated LANES times by a generate loop.
- The top holds the output registers and the counter block.

Test Plan:
- Reset: hold rst_n=0 with random a/b and in_valid=1 -> out_valid=0, S=0, Cout=0, y=0, cnt all 0. Release rst_n mid-cycle -> still 0 until the next edge with in_valid.
- Exhaustive, LANES=1: in_valid=1, apply {a,b}=00,01,10,11 on consecutive cycles -> one cycle later S,Cout = 0,0 / 1,0 / 1,0 / 0,1; y = 0001 / 0010 / 0100 / 1000; each counter reads 1.
- Valid gating: in_valid=0 for 3 cycles with a=1,b=1 -> out_valid=0, y=0, counters unchanged.
- Saturation, CNT_W=2: apply {a,b}=11 for 5 valid cycles -> cnt[3]=3, others 0. Then assert clr_cnt together with a valid 11 -> all counters 0.
- Multi-lane, LANES=4: a=4'b1100, b=4'b1010 -> S=4'b0110, Cout=4'b1000, y=16'h8421 (lane3..lane0 = 1000,0100,0010,0001).
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 -> out_valid, S, Cout, y and cnt drop to 0 immediately without waiting for clk.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decode/half-add cell: the 2-bit input code
// and its one-hot expansion.
package decoder_pkg;

   typedef logic [1:0] code_t;

   localparam code_t CODE_00 = 2'b00;
   localparam code_t CODE_01 = 2'b01;
   localparam code_t CODE_10 = 2'b10;
   localparam code_t CODE_11 = 2'b11;

   function automatic logic [3:0] onehot4(input code_t code);
      logic [3:0] result;
      result = 4'b0000;
      case (code)
         CODE_00: result = 4'b0001;
         CODE_01: result = 4'b0010;
         CODE_10: result = 4'b0100;
         CODE_11: result = 4'b1000;
         default: result = 4'b0000;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/decoder_hadd_lane.sv
// One combinational lane: half-adder sum/carry plus one-hot decode of {a,b}.
module decoder_hadd_lane
   import decoder_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   output logic       s_o,
   output logic       cout_o,
   output logic [3:0] y_o
);

   assign s_o    = a_i ^ b_i;
   assign cout_o = a_i & b_i;
   assign y_o    = onehot4({a_i, b_i});

endmodule

// File: rtl/decoder_hadd.sv
// Registered decode/half-add cell with LANES lanes and saturating per-code
// occurrence counters on lane 0.
module decoder_hadd
   import decoder_pkg::*;
#(
   parameter int LANES = 1,
   parameter int CNT_W = 16
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [LANES-1:0]     a,
   input  logic [LANES-1:0]     b,
   input  logic                 clr_cnt,
   output logic                 out_valid,
   output logic [LANES-1:0]     S,
   output logic [LANES-1:0]     Cout,
   output logic [4*LANES-1:0]   y,
   output logic [4*CNT_W-1:0]   cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [LANES-1:0]   laneS;
   logic [LANES-1:0]   laneCout;
   logic [4*LANES-1:0] laneY;

   logic               validQ, validD;
   logic [LANES-1:0]   sQ, sD;
   logic [LANES-1:0]   coutQ, coutD;
   logic [4*LANES-1:0] yQ, yD;
   logic [CNT_W-1:0]   cntQ [4];
   logic [CNT_W-1:0]   cntD [4];
   code_t              code0;

   for (genvar i = 0; i < LANES; i++) begin : gLane
      decoder_hadd_lane uLane (
         .a_i    (a[i]),
         .b_i    (b[i]),
         .s_o    (laneS[i]),
         .cout_o (laneCout[i]),
         .y_o    (laneY[4*i +: 4])
      );
   end

   assign code0 = {a[0], b[0]};

   // S/Cout keep their last value on idle cycles; y is forced to zero so the
   // one-hot bus never shows a stale code.
   always_comb begin
      validD = in_valid;
      sD     = sQ;
      coutD  = coutQ;
      yD     = '0;
      if (in_valid) begin
         sD    = laneS;
         coutD = laneCout;
         yD    = laneY;
      end
   end

   // A clear wins over a same-cycle increment, so that sample is dropped.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         cntD[k] = cntQ[k];
         if (clr_cnt) begin
            cntD[k] = '0;
         end else if (in_valid && (code0 == code_t'(k)) && (cntQ[k] != CNT_MAX)) begin
            cntD[k] = cntQ[k] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validQ <= 1'b0;
         sQ     <= '0;
         coutQ  <= '0;
         yQ     <= '0;
         for (int k = 0; k < 4; k++) begin
            cntQ[k] <= '0;
         end
      end else begin
         validQ <= validD;
         sQ     <= sD;
         coutQ  <= coutD;
         yQ     <= yD;
         for (int k = 0; k < 4; k++) begin
            cntQ[k] <= cntD[k];
         end
      end
   end

   assign out_valid = validQ;
   assign S         = sQ;
   assign Cout      = coutQ;
   assign y         = yQ;

   for (genvar k = 0; k < 4; k++) begin : gCnt
      assign cnt[CNT_W*k +: CNT_W] = cntQ[k];
   end

endmodule

// File: tb/tb_decoder_hadd.sv
// Directed bench for decoder_hadd: one default instance, a narrow-counter
// instance for saturation, and a four-lane instance for lane placement.
module tb_decoder_hadd;

   logic clk;
   logic rst_n;
   logic inValid;
   logic clrCnt;
   logic a1, b1;
   logic [3:0] a4, b4;

   logic        ovA, sA, cA;
   logic [3:0]  yA;
   logic [63:0] cntA;

   logic        ovB, sB, cB;
   logic [3:0]  yB;
   logic [7:0]  cntB;

   logic        ovC;
   logic [3:0]  sC, cC;
   logic [15:0] yC;
   logic [63:0] cntC;

   int errCount;
   int checkCount;

   decoder_hadd #(.LANES(1), .CNT_W(16)) dutA (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .a(a1), .b(b1), .clr_cnt(clrCnt),
      .out_valid(ovA), .S(sA), .Cout(cA), .y(yA), .cnt(cntA)
   );

   decoder_hadd #(.LANES(1), .CNT_W(2)) dutB (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .a(a1), .b(b1), .clr_cnt(clrCnt),
      .out_valid(ovB), .S(sB), .Cout(cB), .y(yB), .cnt(cntB)
   );

   decoder_hadd #(.LANES(4), .CNT_W(16)) dutC (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .a(a4), .b(b4), .clr_cnt(clrCnt),
      .out_valid(ovC), .S(sC), .Cout(cC), .y(yC), .cnt(cntC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive on the falling edge, then sample 1 time unit after the next rising edge.
   task automatic applyStimulus(input logic valid, input logic aIn, input logic bIn, input logic clr);
      @(negedge clk);
      inValid = valid;
      a1      = aIn;
      b1      = bIn;
      clrCnt  = clr;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] expY [4];
   logic       expS [4];
   logic       expC [4];

   initial begin
      expY[0] = 4'b0001; expS[0] = 1'b0; expC[0] = 1'b0;
      expY[1] = 4'b0010; expS[1] = 1'b1; expC[1] = 1'b0;
      expY[2] = 4'b0100; expS[2] = 1'b1; expC[2] = 1'b0;
      expY[3] = 4'b1000; expS[3] = 1'b0; expC[3] = 1'b1;

      errCount   = 0;
      checkCount = 0;
      rst_n   = 1'b0;
      inValid = 1'b1;
      clrCnt  = 1'b0;
      a1      = 1'b1;
      b1      = 1'b0;
      a4      = 4'b1100;
      b4      = 4'b1010;

      // Reset held while inputs toggle and in_valid is high
      repeat (3) begin
         @(negedge clk);
         a1 = 1'($urandom_range(1));
         b1 = 1'($urandom_range(1));
      end
      @(posedge clk); #1;
      checkOutput("rst_valid", ovA, 0);
      checkOutput("rst_S", sA, 0);
      checkOutput("rst_Cout", cA, 0);
      checkOutput("rst_y", yA, 0);
      checkOutput("rst_cnt", cntA, 0);
      checkOutput("rst_cntSat", cntB, 0);
      checkOutput("rst_y4", yC, 0);

      // Release mid-cycle with in_valid low: outputs stay zero over the next edge
      @(negedge clk);
      inValid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("rel_valid", ovA, 0);
      checkOutput("rel_y", yA, 0);
      checkOutput("rel_S", sA, 0);
      checkOutput("rel_cnt", cntA, 0);

      // Every code on lane 0, one cycle apart
      for (int code = 0; code < 4; code++) begin
         applyStimulus(1'b1, code[1], code[0], 1'b0);
         checkOutput($sformatf("exh_valid_%0d", code), ovA, 1);
         checkOutput($sformatf("exh_S_%0d", code), sA, expS[code]);
         checkOutput($sformatf("exh_Cout_%0d", code), cA, expC[code]);
         checkOutput($sformatf("exh_y_%0d", code), yA, expY[code]);
      end
      checkOutput("exh_cnt", cntA, 64'h0001_0001_0001_0001);
      checkOutput("exh_cntSat", cntB, 8'b01_01_01_01);

      // Lane placement on the 4-lane instance (inputs constant since reset)
      checkOutput("ml_valid", ovC, 1);
      checkOutput("ml_S", sC, 4'b0110);
      checkOutput("ml_Cout", cC, 4'b1000);
      checkOutput("ml_y", yC, 16'h8421);
      checkOutput("ml_cnt", cntC, 64'h0000_0000_0000_0004);

      // Idle cycles with a=b=1 must not count or show a code
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
         checkOutput($sformatf("gate_valid_%0d", i), ovA, 0);
         checkOutput($sformatf("gate_y_%0d", i), yA, 0);
      end
      checkOutput("gate_cnt", cntA, 64'h0001_0001_0001_0001);

      // Clear on an idle cycle, then five 11 samples: 2-bit counter sticks at 3
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("clr_idle_cnt", cntA, 0);
      repeat (5) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("sat_cntSat", cntB, 8'b11_00_00_00);
      checkOutput("sat_cnt", cntA, 64'h0005_0000_0000_0000);

      // Clear wins over a simultaneous valid 11, and leaves the datapath alone
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("clrpri_cntSat", cntB, 0);
      checkOutput("clrpri_cnt", cntA, 0);
      checkOutput("clrpri_valid", ovA, 1);
      checkOutput("clrpri_y", yA, 4'b1000);
      checkOutput("clrpri_Cout", cA, 1);

      // Asynchronous reset between edges while a result is being shown
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("pre_valid", ovA, 1);
      checkOutput("pre_cnt", cntA, 64'h0000_0001_0000_0000);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_valid", ovA, 0);
      checkOutput("async_S", sA, 0);
      checkOutput("async_Cout", cA, 0);
      checkOutput("async_y", yA, 0);
      checkOutput("async_cnt", cntA, 0);
      checkOutput("async_y4", yC, 0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
